// File: rtl/mux_writer_pkg.sv
// rtl/mux_writer_pkg.sv - shared types and constants for the mux_writer slice
package mux_writer_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int DATA_W    = 4;
    localparam int CNT_W     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/mux_writer_slot_counter.sv
// rtl/mux_writer_slot_counter.sv - 2-bit slot index counter with clear, enable and terminal flag
module mux_writer_slot_counter
    import mux_writer_pkg::*;
(
    input  logic             clk,
    input  logic             res,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    // Slot index register; clear beats enable, wraps 3 -> 0 when enabled.
    always_ff @(posedge clk) begin
        if (res || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == CNT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/mux_writer.sv
// rtl/mux_writer.sv - captures four nibbles on start and writes them to consecutive RAM addresses
module mux_writer
    import mux_writer_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              res,
    input  logic              dis,
    input  logic              start,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [CNT_W-1:0]  muxcount,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t state;
    state_t state_next;

    logic [DATA_W-1:0] shadow [NUM_SLOTS];

    // The counter leads the registered outputs by one slot: slot 0 is issued
    // straight from in0 on the capture edge, so the counter holds the index of
    // the slot to issue on the following edge.
    logic [CNT_W-1:0] cnt;
    logic             cnt_term;
    logic             cnt_en;
    logic             cnt_clr;
    logic             load;

    logic              we_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next;
    logic [CNT_W-1:0]  muxcount_next;
    logic              busy_next;
    logic              done_next;

    mux_writer_slot_counter u_slot_counter (
        .clk   (clk),
        .res   (res),
        .clr   (dis || cnt_clr),
        .en    (cnt_en),
        .count (cnt),
        .term  (cnt_term)
    );

    // Next-state and next-output decode; address and data hold outside WRITE.
    always_comb begin
        state_next    = state;
        we_next       = 1'b0;
        addr_next     = mem_addr;
        wdata_next    = mem_wdata;
        muxcount_next = '0;
        busy_next     = 1'b0;
        done_next     = 1'b0;
        load          = 1'b0;
        cnt_en        = 1'b0;
        cnt_clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WRITE;
                    we_next    = 1'b1;
                    addr_next  = BASE;
                    wdata_next = in0;
                    busy_next  = 1'b1;
                    load       = 1'b1;
                    cnt_en     = 1'b1;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            WRITE: begin
                we_next       = 1'b1;
                addr_next     = BASE + ADDR_W'(cnt);
                wdata_next    = shadow[cnt];
                muxcount_next = cnt;
                busy_next     = 1'b1;
                cnt_en        = 1'b1;
                if (cnt_term) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_next  = 1'b1;
                state_next = IDLE;
                cnt_clr    = 1'b1;
            end
            default: begin
                state_next = IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    // State register; reset and disable both force IDLE.
    always_ff @(posedge clk) begin
        if (res || dis) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered RAM port and status outputs.
    always_ff @(posedge clk) begin
        if (res || dis) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            muxcount  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            muxcount  <= muxcount_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    // Shadow copy of the inputs so later input changes cannot disturb a sequence.
    always_ff @(posedge clk) begin
        if (res || dis) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i] <= '0;
            end
        end else if (load) begin
            shadow[0] <= in0;
            shadow[1] <= in1;
            shadow[2] <= in2;
            shadow[3] <= in3;
        end
    end

endmodule

// File: doc/mux_writer.md
Name: mux_writer

Overview:
Write-side counterpart of the display demux path. It captures four 4-bit values (slot 0-3) on a start strobe and serialises them into RAM, one nibble per clock, at consecutive addresses from a base address. It drives the RAM write port (data, address, write-enable) and a 2-bit slot index with the same 0-3 meaning as the read-side muxcount. It reports busy/done to the controlling FSM.

Parameters:
ADDR_W, 4, RAM address width in bits
BASE_ADDR, 0, RAM address of slot 0; slot n goes to BASE_ADDR+n (modulo 2^ADDR_W)

Ports:
clk  input  1  system clock; all state changes on its rising edge
res  input  1  reset, synchronous, active-high
dis  input  1  disable; synchronous abort, same effect as res but lower priority
start  input  1  request to write in0..in3; sampled only in IDLE
in0  input  4  data for slot 0
in1  input  4  data for slot 1
in2  input  4  data for slot 2
in3  input  4  data for slot 3
mem_we  output  1  RAM write enable, one cycle per slot
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  4  RAM write data
muxcount  output  2  slot index currently written (0-3)
busy  output  1  high while a 4-slot sequence is in progress
done  output  1  single-cycle pulse after slot 3 is written

Behaviour:
- Interface decision: one clock (clk); reset res is synchronous and active-high. No asynchronous reset anywhere.
- All outputs are registered.
- Reset (res=1 at an edge): state=IDLE; mem_we=0, mem_addr=0, mem_wdata=0, muxcount=0, busy=0, done=0; shadow registers cleared.
- dis=1 at an edge (res=0): same result as reset.
- Priority: res > dis > start.
- States:
  - IDLE: start=1 -> capture in0..in3 into shadow regs, muxcount<=0, go WRITE. Otherwise stay.
  - WRITE: each cycle drive mem_we=1, mem_addr=BASE_ADDR+muxcount, mem_wdata=shadow[muxcount]. muxcount increments. After the slot-3 cycle, go DONE.
  - DONE: mem_we=0, done=1 for exactly one cycle, then IDLE.
- Timing (edge k samples start=1 in IDLE):
  - Cycles k+1..k+4: mem_we=1 with slot 0,1,2,3.
  - Cycle k+5: done=1.
  - busy=1 during cycles k+1..k+4.
  - Earliest next start is sampled at edge k+5, giving a 5-cycle repetition.
- start while busy or in DONE: ignored; no queueing.
- Inputs in0..in3 may change after the capture edge without affecting the sequence.
- Outside WRITE: mem_we=0; mem_addr and mem_wdata hold their last values; muxcount returns to 0 on entry to IDLE.
- Address arithmetic: ADDR_W-bit add, wraps silently past 2^ADDR_W-1.
- res or dis mid-sequence: remaining slots are not written, no done pulse, next cycle is IDLE with reset output values. Slots already written stay in RAM.
- start and dis at the same edge: dis wins and nothing is captured.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, WRITE=2'd1, DONE=2'd2), NUM_SLOTS=4, DATA_W=4.
- Sub-module slot_counter: 2-bit counter with synchronous clear and enable, and a terminal flag at 3. It is reusable as the read-side muxcount source.

Test Plan:
- Reset: res=1 for 2 cycles with start=1 -> all outputs 0, no mem_we.
- Nominal: BASE_ADDR=4, in0..in3=A,B,C,D, start pulse -> mem_we at addr 4,5,6,7 with data A,B,C,D and muxcount 0,1,2,3; done one cycle later; busy high for exactly 4 cycles.
- Wrap: ADDR_W=4, BASE_ADDR=14 -> writes to addresses 14,15,0,1.
- Ignore and isolation: start held high continuously, with in0..in3 changed to 0xF after capture -> RAM gets the original values; next sequence starts 5 cycles after the first; no overlap.
- Abort: dis=1 during slot-1 write -> slots 2,3 not written, no done, outputs 0 next cycle; a later start completes normally.
- Priority: start and dis at the same edge -> stays IDLE. res=1 with dis=0 mid-sequence -> identical outcome to the abort case.
